// File: rtl/dht11_if.sv
// Control and status bundle of the DHT11 emulator: sensor values and
// enable go in, status pulses and the debug state come out.
interface dht11_if;
    logic       en;
    logic [7:0] hum_int;
    logic [7:0] hum_dec;
    logic [7:0] temp_int;
    logic [7:0] temp_dec;
    logic       busy;
    logic       frame_done;
    logic       start_err;
    logic [3:0] state_debug;

    modport master (
        output en, hum_int, hum_dec, temp_int, temp_dec,
        input  busy, frame_done, start_err, state_debug
    );

    modport slave (
        input  en, hum_int, hum_dec, temp_int, temp_dec,
        output busy, frame_done, start_err, state_debug
    );
endinterface

// File: rtl/dht11_emulator.sv
// DHT11 sensor-side responder. Waits for a host start pulse on the shared
// data line, answers with the 80/80 us preamble and shifts out the 40-bit
// frame {hum_int, hum_dec, temp_int, temp_dec, checksum}, MSB first.
module dht11_emulator #(
    parameter int unsigned START_MIN  = 400_000,
    parameter int unsigned START_MAX  = 2_500_000,
    parameter int unsigned T_RESP_DLY = 1_500,
    parameter int unsigned T_RESP     = 4_000,
    parameter int unsigned T_BIT_LOW  = 2_500,
    parameter int unsigned T_ZERO     = 1_350,
    parameter int unsigned T_ONE      = 3_500,
    parameter bit          OPEN_DRAIN = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    inout  wire    dht11_io,
    dht11_if.slave bus
);
    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] START_LOW = 4'd1;
    localparam logic [3:0] RESP_DLY  = 4'd2;
    localparam logic [3:0] RESP_LOW  = 4'd3;
    localparam logic [3:0] RESP_HIGH = 4'd4;
    localparam logic [3:0] BIT_LOW   = 4'd5;
    localparam logic [3:0] BIT_HIGH  = 4'd6;
    localparam logic [3:0] END_LOW   = 4'd7;
    localparam logic [3:0] ERR_WAIT  = 4'd8;

    logic [3:0]  state_reg;
    logic [31:0] cnt_reg;
    logic [5:0]  bit_cnt_reg;
    logic [39:0] shreg_reg;
    logic        busy_reg;
    logic        frame_done_reg;
    logic        start_err_reg;
    logic        sync1_reg;
    logic        sync2_reg;
    logic        prev_reg;

    logic        line_fall;
    logic        line_rise;
    logic [7:0]  checksum;
    logic [31:0] phase_len;
    logic        phase_end;
    logic        drive_low;
    logic        drive_high;

    // Two-flop synchronizer plus one delay stage for edge detection; reset to
    // the idle-high level so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= dht11_io;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign line_fall = prev_reg & ~sync2_reg;
    assign line_rise = ~prev_reg & sync2_reg;
    assign checksum  = bus.hum_int + bus.hum_dec + bus.temp_int + bus.temp_dec;

    // Length of the timed phase the FSM currently sits in.
    always_comb begin
        phase_len = T_BIT_LOW;
        case (state_reg)
            RESP_DLY:            phase_len = T_RESP_DLY;
            RESP_LOW, RESP_HIGH: phase_len = T_RESP;
            BIT_HIGH:            phase_len = shreg_reg[39] ? T_ONE : T_ZERO;
            default:             phase_len = T_BIT_LOW;
        endcase
    end

    // Counter runs 0..N-1 inside a phase, so each phase lasts exactly N cycles.
    assign phase_end = (cnt_reg == phase_len - 32'd1);

    // Protocol FSM: start qualification, preamble, bit slots and end-of-frame low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_cnt_reg    <= '0;
            shreg_reg      <= '0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            start_err_reg  <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            start_err_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.en && line_fall) begin
                        state_reg <= START_LOW;
                        cnt_reg   <= '0;
                    end
                end
                START_LOW: begin
                    if (line_rise) begin
                        cnt_reg <= '0;
                        if (cnt_reg < START_MIN) begin
                            start_err_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end else begin
                            shreg_reg   <= {bus.hum_int, bus.hum_dec, bus.temp_int,
                                            bus.temp_dec, checksum};
                            bit_cnt_reg <= '0;
                            busy_reg    <= 1'b1;
                            state_reg   <= RESP_DLY;
                        end
                    end else if (cnt_reg >= START_MAX - 32'd1) begin
                        cnt_reg       <= START_MAX;
                        start_err_reg <= 1'b1;
                        state_reg     <= ERR_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                ERR_WAIT: begin
                    if (line_rise) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end
                end
                RESP_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW: begin
                    if (!phase_end) begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end else begin
                        cnt_reg <= '0;
                        case (state_reg)
                            RESP_DLY:  state_reg <= RESP_LOW;
                            RESP_LOW:  state_reg <= RESP_HIGH;
                            RESP_HIGH: state_reg <= BIT_LOW;
                            BIT_LOW:   state_reg <= BIT_HIGH;
                            BIT_HIGH: begin
                                shreg_reg   <= {shreg_reg[38:0], 1'b0};
                                bit_cnt_reg <= bit_cnt_reg + 6'd1;
                                state_reg   <= (bit_cnt_reg == 6'd39) ? END_LOW : BIT_LOW;
                            end
                            default: begin
                                busy_reg       <= 1'b0;
                                frame_done_reg <= 1'b1;
                                state_reg      <= IDLE;
                            end
                        endcase
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Line driver decoded from the registered state; high phases are only
    // actively driven in push-pull mode.
    assign drive_low  = (state_reg == RESP_LOW) || (state_reg == BIT_LOW) ||
                        (state_reg == END_LOW);
    assign drive_high = !OPEN_DRAIN &&
                        ((state_reg == RESP_HIGH) || (state_reg == BIT_HIGH));
    assign dht11_io   = drive_low ? 1'b0 : (drive_high ? 1'b1 : 1'bz);

    assign bus.busy        = busy_reg;
    assign bus.frame_done  = frame_done_reg;
    assign bus.start_err   = start_err_reg;
    assign bus.state_debug = state_reg;
endmodule

// File: tb/tb_dht11_emulator.sv
// Bench for dht11_emulator with shortened timing parameters. A host model
// pulls the line low, then the line is sampled every cycle and the measured
// low/high runs are compared with a waveform built from the protocol rules.
module tb_dht11_emulator;
    localparam int SMIN = 40;
    localparam int SMAX = 250;
    localparam int TRD  = 15;
    localparam int TR   = 40;
    localparam int TBL  = 25;
    localparam int TZ   = 13;
    localparam int TO   = 35;
    localparam int CHG_WAIT = TRD + 3 + 2 * TR + 10 * TBL + 10 * ((TZ + TO) / 2) + TBL / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic host_low = 1'b0;
    logic use_pp = 1'b0;
    wire  io_od;
    wire  io_pp;

    always #5 clk = ~clk;

    pullup (io_od);
    pullup (io_pp);
    assign io_od = (host_low && !use_pp) ? 1'b0 : 1'bz;
    assign io_pp = (host_low && use_pp) ? 1'b0 : 1'bz;

    dht11_if if_od ();
    dht11_if if_pp ();

    dht11_emulator #(
        .START_MIN(SMIN), .START_MAX(SMAX), .T_RESP_DLY(TRD), .T_RESP(TR),
        .T_BIT_LOW(TBL), .T_ZERO(TZ), .T_ONE(TO), .OPEN_DRAIN(1'b1)
    ) dut_od (
        .clk(clk), .rst(rst), .dht11_io(io_od), .bus(if_od)
    );

    dht11_emulator #(
        .START_MIN(SMIN), .START_MAX(SMAX), .T_RESP_DLY(TRD), .T_RESP(TR),
        .T_BIT_LOW(TBL), .T_ZERO(TZ), .T_ONE(TO), .OPEN_DRAIN(1'b0)
    ) dut_pp (
        .clk(clk), .rst(rst), .dht11_io(io_pp), .bus(if_pp)
    );

    wire       line      = use_pp ? io_pp : io_od;
    wire       sel_busy  = use_pp ? if_pp.busy : if_od.busy;
    wire       sel_fd    = use_pp ? if_pp.frame_done : if_od.frame_done;
    wire       sel_se    = use_pp ? if_pp.start_err : if_od.start_err;
    wire [3:0] sel_state = use_pp ? if_pp.state_debug : if_od.state_debug;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int fd_cnt = 0;
    int se_cnt = 0;
    int se_cyc = 0;
    int  seg_len[$];
    bit  seg_lvl[$];

    // Pulse counters for the selected DUT, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (sel_fd === 1'b1) fd_cnt <= fd_cnt + 1;
        if (sel_se === 1'b1) begin
            se_cnt <= se_cnt + 1;
            se_cyc <= cyc;
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: got no end of run, want finish before 80000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic set_inputs(input logic [7:0] a, b, c, d);
        if_od.hum_int = a; if_od.hum_dec = b; if_od.temp_int = c; if_od.temp_dec = d;
        if_pp.hum_int = a; if_pp.hum_dec = b; if_pp.temp_int = c; if_pp.temp_dec = d;
    endtask

    task automatic set_en(input logic e);
        if_od.en = e;
        if_pp.en = e;
    endtask

    task automatic host_press(input int cycles);
        @(negedge clk);
        host_low = 1'b1;
        repeat (cycles) @(negedge clk);
        host_low = 1'b0;
    endtask

    // Records consecutive line levels as (level, length) runs until the line
    // has idled high for 200 cycles; the trailing idle run is not stored.
    task automatic measure_frame();
        bit cur;
        int run;
        seg_len.delete();
        seg_lvl.delete();
        @(negedge clk);
        cur = line;
        run = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (line === cur) begin
                run++;
                if (cur && run > 200) break;
            end else begin
                seg_lvl.push_back(cur);
                seg_len.push_back(run);
                cur = line;
                run = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (sel_state !== 4'd0) $display("FAIL reset_state: got %0d want 0", sel_state); else passed++;
        total++; if (sel_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", sel_busy); else passed++;
        total++; if (sel_fd !== 1'b0 || sel_se !== 1'b0) $display("FAIL reset_pulses: got fd %b se %b want 0 0", sel_fd, sel_se); else passed++;
        total++; if (line !== 1'b1) $display("FAIL reset_line: got %b want 1 (released)", line); else passed++;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (sel_state !== 4'd0 || sel_busy !== 1'b0) $display("FAIL post_reset_idle: got state %0d busy %b want 0 0", sel_state, sel_busy); else passed++;
        $display("reset: state %0d busy %b line %b", sel_state, sel_busy, line);
    endtask

    task automatic test_frame(input string name, input logic [7:0] h_i, h_d, t_i, t_d, input bit change_mid);
        logic [7:0]  ck;
        logic [39:0] frame;
        logic [39:0] got;
        int exp_len[$];
        bit exp_lvl[$];
        int fd0;
        int hl;
        int n;
        ck = h_i + h_d + t_i + t_d;
        frame = {h_i, h_d, t_i, t_d, ck};
        exp_lvl.push_back(1'b1); exp_len.push_back(TRD);
        exp_lvl.push_back(1'b0); exp_len.push_back(TR);
        exp_lvl.push_back(1'b1); exp_len.push_back(TR);
        for (int i = 39; i >= 0; i--) begin
            exp_lvl.push_back(1'b0); exp_len.push_back(TBL);
            exp_lvl.push_back(1'b1); exp_len.push_back(frame[i] ? TO : TZ);
        end
        exp_lvl.push_back(1'b0); exp_len.push_back(TBL);
        set_inputs(h_i, h_d, t_i, t_d);
        set_en(1'b1);
        fd0 = fd_cnt;
        hl = $urandom_range(SMAX - 20, SMIN + 5);
        host_press(hl);
        fork
            measure_frame();
            begin
                repeat (5) @(negedge clk);
                total++; if (sel_busy !== 1'b1) $display("FAIL %s busy_after_accept: got %b want 1", name, sel_busy); else passed++;
                if (change_mid) begin
                    repeat (CHG_WAIT - 5) @(negedge clk);
                    set_inputs(~h_i, ~h_d, ~t_i, ~t_d);
                end
            end
        join
        n = seg_len.size();
        total++; if (n != 84) $display("FAIL %s segment_count: got %0d want 84", name, n); else passed++;
        total++;
        if (n < 1 || seg_lvl[0] !== 1'b1 || seg_len[0] < TRD || seg_len[0] > TRD + 4)
            $display("FAIL %s resp_delay: got %0d cycles want %0d..%0d", name, (n > 0) ? seg_len[0] : -1, TRD, TRD + 4);
        else passed++;
        for (int i = 1; i < 84; i++) begin
            total++;
            if (i >= n || seg_lvl[i] !== exp_lvl[i] || seg_len[i] != exp_len[i])
                $display("FAIL %s seg%0d: got lvl %b len %0d want lvl %b len %0d", name, i,
                         (i < n) ? seg_lvl[i] : 1'b0, (i < n) ? seg_len[i] : -1, exp_lvl[i], exp_len[i]);
            else passed++;
        end
        got = '0;
        for (int k = 0; k < 40; k++)
            if (4 + 2 * k < n) got[39 - k] = (seg_len[4 + 2 * k] > (TZ + TO) / 2);
        for (int b = 0; b < 5; b++) begin
            total++;
            if (got[39 - 8 * b -: 8] !== frame[39 - 8 * b -: 8])
                $display("FAIL %s byte%0d: got %02h want %02h", name, b, got[39 - 8 * b -: 8], frame[39 - 8 * b -: 8]);
            else passed++;
        end
        total++; if (fd_cnt - fd0 != 1) $display("FAIL %s frame_done_count: got %0d want 1", name, fd_cnt - fd0); else passed++;
        total++; if (sel_busy !== 1'b0 || sel_state !== 4'd0) $display("FAIL %s idle_after: got busy %b state %0d want 0 0", name, sel_busy, sel_state); else passed++;
        $display("frame %s: sent %010h decoded %010h segments %0d", name, frame, got, n);
    endtask

    task automatic test_short_start();
        int se0;
        int lows;
        se0 = se_cnt;
        set_en(1'b1);
        host_press(SMIN / 2);
        repeat (10) @(negedge clk);
        total++; if (se_cnt - se0 != 1) $display("FAIL short_start_err: got %0d pulses want 1", se_cnt - se0); else passed++;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (line !== 1'b1) lows++;
        end
        total++; if (lows != 0) $display("FAIL short_start_line: got %0d low cycles want 0", lows); else passed++;
        total++; if (sel_state !== 4'd0 || sel_busy !== 1'b0) $display("FAIL short_start_idle: got state %0d busy %b want 0 0", sel_state, sel_busy); else passed++;
        $display("short start: start_err pulses %0d, line low cycles %0d", se_cnt - se0, lows);
    endtask

    task automatic test_stuck_low();
        int se0;
        int t0;
        int lows;
        int busy_seen;
        se0 = se_cnt;
        set_en(1'b1);
        @(negedge clk);
        t0 = cyc;
        host_low = 1'b1;
        repeat (SMAX + 30) @(negedge clk);
        total++; if (sel_state !== 4'd8) $display("FAIL stuck_err_wait: got state %0d want 8", sel_state); else passed++;
        repeat (20) @(negedge clk);
        host_low = 1'b0;
        repeat (10) @(negedge clk);
        total++; if (se_cnt - se0 != 1) $display("FAIL stuck_err_count: got %0d want 1", se_cnt - se0); else passed++;
        total++; if (se_cyc - t0 < SMAX || se_cyc - t0 > SMAX + 5) $display("FAIL stuck_err_time: got %0d want %0d..%0d", se_cyc - t0, SMAX, SMAX + 5); else passed++;
        total++; if (sel_state !== 4'd0) $display("FAIL stuck_back_idle: got state %0d want 0", sel_state); else passed++;
        lows = 0;
        busy_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (line !== 1'b1) lows++;
            if (sel_busy === 1'b1) busy_seen++;
        end
        total++; if (lows != 0 || busy_seen != 0) $display("FAIL stuck_no_response: got %0d low %0d busy cycles want 0 0", lows, busy_seen); else passed++;
        $display("stuck low: start_err at +%0d cycles", se_cyc - t0);
    endtask

    task automatic test_en_low();
        int se0;
        int lows;
        int busy_seen;
        se0 = se_cnt;
        set_en(1'b0);
        host_press((SMIN + SMAX) / 2);
        lows = 0;
        busy_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (line !== 1'b1) lows++;
            if (sel_busy === 1'b1) busy_seen++;
        end
        total++; if (lows != 0 || busy_seen != 0) $display("FAIL en_low_response: got %0d low %0d busy cycles want 0 0", lows, busy_seen); else passed++;
        total++; if (se_cnt != se0) $display("FAIL en_low_start_err: got %0d pulses want 0", se_cnt - se0); else passed++;
        set_en(1'b1);
        $display("en low: line low cycles %0d busy cycles %0d", lows, busy_seen);
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        int w;
        int lows;
        set_inputs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        set_en(1'b1);
        fd0 = fd_cnt;
        host_press((SMIN + SMAX) / 2);
        repeat (TRD + 3 + 2 * TR + 20 * (TBL + (TZ + TO) / 2)) @(negedge clk);
        w = 0;
        while (line !== 1'b0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        total++; if (line !== 1'b0) $display("FAIL midreset_wait_low: got line %b after %0d cycles want 0", line, w); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (line !== 1'b1) $display("FAIL midreset_line: got %b want 1 (released)", line); else passed++;
        total++; if (sel_busy !== 1'b0 || sel_state !== 4'd0) $display("FAIL midreset_idle: got busy %b state %0d want 0 0", sel_busy, sel_state); else passed++;
        rst = 1'b1;
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (line !== 1'b1) lows++;
        end
        total++; if (fd_cnt != fd0 || lows != 0) $display("FAIL midreset_quiet: got %0d frame_done %0d low cycles want 0 0", fd_cnt - fd0, lows); else passed++;
        $display("reset mid-frame: frame_done pulses %0d line low cycles %0d", fd_cnt - fd0, lows);
    endtask

    initial begin
        set_inputs(8'h00, 8'h00, 8'h00, 8'h00);
        set_en(1'b1);
        test_reset();
        test_frame("fixed", 8'h37, 8'h00, 8'h18, 8'h00, 1'b0);
        test_frame("wrap", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        test_frame("random", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        test_frame("midchange", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        test_short_start();
        test_frame("after_short", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        test_stuck_low();
        test_en_low();
        test_reset_mid_frame();
        test_frame("after_reset", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        use_pp = 1'b1;
        repeat (5) @(negedge clk);
        test_frame("pushpull", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        test_frame("pushpull_wrap", 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
